// File: rtl/xpb_digit_accumulator.sv
// xpb_digit_accumulator
// Splits the overflow bits of a wide product into table-address digits. It
// presents one digit per cycle to an external combinational xpb lookup and
// adds each returned constant onto the lower product segment. The result is
// redundant, not fully reduced, and carries GUARD_BITS of headroom so that it
// can never wrap.
//
// Handshake: start is a request that is sampled only in IDLE or DONE. It is
// ignored while busy. done is a single-cycle pulse, and sum_out is valid from
// that cycle until the next accepted start completes. The lookup port has no
// flow control. lut_data must be a combinational function of
// (lut_sel, lut_digit) within the same cycle.
module xpb_digit_accumulator #(
  parameter int DIGIT_BITS = 5,
  parameter int NUM_DIGITS = 8,
  parameter int ACC_BITS   = 1024,
  parameter int GUARD_BITS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] upper_in,
  input  logic [ACC_BITS-1:0]              base_in,
  output logic [$clog2(NUM_DIGITS)-1:0]    lut_sel,
  output logic [DIGIT_BITS-1:0]            lut_digit,
  input  logic [ACC_BITS-1:0]              lut_data,
  output logic                             busy,
  output logic                             done,
  output logic [ACC_BITS+GUARD_BITS-1:0]   sum_out
);

  localparam int SUM_BITS = ACC_BITS + GUARD_BITS;
  localparam int SEL_W    = $clog2(NUM_DIGITS);
  localparam int UPPER_W  = NUM_DIGITS * DIGIT_BITS;
  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;
  logic [UPPER_W-1:0]   digit_q, digit_d;
  logic [DIGIT_BITS-1:0] lut_digit_q, lut_digit_d;
  logic [SUM_BITS-1:0]  acc_q, acc_d;
  logic [SUM_BITS-1:0]  sum_q, sum_d;

  logic                 accept;
  logic                 last_digit;
  logic [SUM_BITS-1:0]  lut_ext;
  logic [SUM_BITS-1:0]  acc_plus;

  assign accept     = start && (state_q != S_ACCUM);
  assign last_digit = (state_q == S_ACCUM) && (cnt_q == LAST_CNT);
  assign lut_ext    = {{GUARD_BITS{1'b0}}, lut_data};
  assign acc_plus   = acc_q + lut_ext;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. DONE accepts a new start directly for back-to-back work.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == S_ACCUM);
    done = (state_q == S_DONE);
  end

  // Datapath next values. The digit register shifts down so that the next
  // digit is always in the low slot. This lets the table address come straight
  // from a flop instead of a wide mux.
  always_comb begin
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    lut_digit_d = lut_digit_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    if (accept) begin
      cnt_d       = '0;
      digit_d     = upper_in >> DIGIT_BITS;
      lut_digit_d = upper_in[DIGIT_BITS-1:0];
      acc_d       = {{GUARD_BITS{1'b0}}, base_in};
    end else if (state_q == S_ACCUM) begin
      acc_d = acc_plus;
      if (last_digit) begin
        // Park the table address at zero outside ACCUM and publish the sum.
        cnt_d       = '0;
        lut_digit_d = '0;
        sum_d       = acc_plus;
      end else begin
        cnt_d       = cnt_q + SEL_W'(1);
        lut_digit_d = digit_q[DIGIT_BITS-1:0];
        digit_d     = digit_q >> DIGIT_BITS;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      digit_q     <= '0;
      lut_digit_q <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      lut_digit_q <= lut_digit_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
    end
  end

  assign lut_sel   = cnt_q;
  assign lut_digit = lut_digit_q;
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_xpb_digit_accumulator.sv
// Directed bench for xpb_digit_accumulator. It provides a behavioural lookup
// table of lut_digit*(lut_sel+1), with an all-ones override for the carry case.
module tb_xpb_digit_accumulator;

  localparam int DB  = 5;
  localparam int ND  = 8;
  localparam int AB  = 1024;
  localparam int GB  = 4;
  localparam int SB  = AB + GB;
  localparam int SW  = $clog2(ND);
  localparam int UW  = ND * DB;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [UW-1:0] upper_in;
  logic [AB-1:0] base_in;
  logic [SW-1:0] lut_sel;
  logic [DB-1:0] lut_digit;
  logic [AB-1:0] lut_data;
  logic          busy;
  logic          done;
  logic [SB-1:0] sum_out;
  logic          force_ones;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xpb_digit_accumulator #(
    .DIGIT_BITS(DB), .NUM_DIGITS(ND), .ACC_BITS(AB), .GUARD_BITS(GB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in),
    .base_in(base_in), .lut_sel(lut_sel), .lut_digit(lut_digit),
    .lut_data(lut_data), .busy(busy), .done(done), .sum_out(sum_out)
  );

  // Behavioural xpb table.
  always_comb begin
    if (force_ones) lut_data = {AB{1'b1}};
    else            lut_data = AB'(int'(lut_digit) * (int'(lut_sel) + 1));
  end

  // Safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [SB-1:0] got, input logic [SB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h..%h exp=%h..%h", tag, got[SB-1:SB-36], got[31:0],
               exp[SB-1:SB-36], exp[31:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Issues start before the next rising edge. It then follows the operation
  // through its eight ACCUM cycles and returns during the DONE cycle, sampling
  // on falling edges. hold_sum is the value sum_out must keep while ACCUM runs.
  task automatic run_op(input string tag, input logic [UW-1:0] upper,
                        input logic [AB-1:0] base, input logic [SB-1:0] exp_sum,
                        input logic [SB-1:0] hold_sum, input bit perturb);
    start    = 1'b1;
    upper_in = upper;
    base_in  = base;
    @(posedge clk);
    #1;
    start    = 1'b0;
    upper_in = UW'({$urandom, $urandom});
    base_in  = ~base;
    for (int k = 0; k < ND; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, SB'(busy), SB'(1));
      chk({tag, "_done_low"}, SB'(done), SB'(0));
      chk({tag, "_sel"}, SB'(lut_sel), SB'(k));
      chk({tag, "_digit"}, SB'(lut_digit), SB'(upper[k*DB +: DB]));
      chk({tag, "_hold"}, sum_out, hold_sum);
      if (perturb && k == 2) begin
        start    = 1'b1;
        upper_in = UW'({$urandom, $urandom});
      end
      if (perturb && k == 3) start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done"}, SB'(done), SB'(1));
    chk({tag, "_busy_off"}, SB'(busy), SB'(0));
    chk({tag, "_sel_idle"}, SB'(lut_sel), SB'(0));
    chk({tag, "_sum"}, sum_out, exp_sum);
  endtask

  // One cycle after DONE with no start pending: idle and the sum is held.
  task automatic chk_idle(input string tag, input logic [SB-1:0] exp_sum);
    @(negedge clk);
    chk({tag, "_idle_done"}, SB'(done), SB'(0));
    chk({tag, "_idle_busy"}, SB'(busy), SB'(0));
    chk({tag, "_idle_digit"}, SB'(lut_digit), SB'(0));
    chk({tag, "_idle_sum"}, sum_out, exp_sum);
  endtask

  // ---------------- stimulus ----------------
  logic [UW-1:0] ones_d, twos_d, max_d, ord_d;
  logic [SB-1:0] big_sum;

  initial begin
    ones_d  = {ND{5'd1}};
    twos_d  = {ND{5'd2}};
    max_d   = {ND{5'd31}};
    ord_d   = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    big_sum = {4'h8, {(AB-4){1'b1}}, 4'h7};   // 9*(2^1024-1)

    rst_n      = 1'b0;
    start      = 1'b0;
    upper_in   = '0;
    base_in    = '0;
    force_ones = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", SB'(busy), SB'(0));
    chk("rst_done", SB'(done), SB'(0));
    chk("rst_sum", sum_out, SB'(0));
    chk("rst_sel", SB'(lut_sel), SB'(0));
    chk("rst_digit", SB'(lut_digit), SB'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: base 0, all digits 1 -> 1+2+...+8 = 36
    run_op("basic", ones_d, '0, SB'(36), SB'(0), 1'b0);
    @(negedge clk);
    chk("basic_pulse_width", SB'(done), SB'(0));
    chk("basic_held", sum_out, SB'(36));

    // Carry/guard: all-ones base plus eight all-ones table words
    force_ones = 1'b1;
    run_op("carry", max_d, {AB{1'b1}}, big_sum, SB'(36), 1'b0);
    force_ones = 1'b0;
    chk_idle("carry", big_sum);

    // Back-to-back: second start lands in the DONE cycle of the first
    run_op("b2b_first", ones_d, '0, SB'(36), big_sum, 1'b0);
    run_op("b2b_second", twos_d, AB'(5), SB'(77), SB'(36), 1'b0);
    chk_idle("b2b", SB'(77));

    // Digit ordering: digit i = i+1 -> sum of squares 1..8 = 204
    run_op("order", ord_d, '0, SB'(204), SB'(77), 1'b0);
    chk_idle("order", SB'(204));

    // Start pulsed at edge 3 with new upper_in must not disturb anything
    run_op("ignored", ord_d, '0, SB'(204), SB'(204), 1'b1);
    chk_idle("ignored", SB'(204));

    // Reset in the middle of ACCUM
    @(negedge clk);
    start    = 1'b1;
    upper_in = ones_d;
    base_in  = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", SB'(busy), SB'(0));
    chk("midrst_sum", sum_out, SB'(0));
    chk("midrst_done", SB'(done), SB'(0));
    chk("midrst_sel", SB'(lut_sel), SB'(0));
    chk("midrst_digit", SB'(lut_digit), SB'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("postrst_no_done", SB'(done), SB'(0));
      chk("postrst_no_busy", SB'(busy), SB'(0));
    end
    run_op("fresh", ones_d, '0, SB'(36), SB'(0), 1'b0);
    chk_idle("fresh", SB'(36));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
